// File: rtl/nand_serial_adder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : nand_serial_adder (with nand_gate, nand_4_group cells)    |
// | Purpose  : Bit-serial unsigned adder, LSB first, one bit per clock,  |
// |            built from a NAND-only full-adder cell, valid/ready I/O.  |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+

// Single two-input NAND, the only primitive used by the adder cell.
module nand_gate (
  input  logic a_i,
  input  logic b_i,
  output logic y_o
);
  assign y_o = ~(a_i & b_i);
endmodule

// Four-NAND group: l_o is NAND(x,y), r_o is x XOR y built from NANDs.
module nand_4_group (
  input  logic x_i,
  input  logic y_i,
  output logic l_o,
  output logic r_o
);
  logic w_n1;
  logic w_n2;
  logic w_n3;

  nand_gate u_n1 (.a_i(x_i), .b_i(y_i),  .y_o(w_n1));
  nand_gate u_n2 (.a_i(x_i), .b_i(w_n1), .y_o(w_n2));
  nand_gate u_n3 (.a_i(y_i), .b_i(w_n1), .y_o(w_n3));
  nand_gate u_n4 (.a_i(w_n2), .b_i(w_n3), .y_o(r_o));

  assign l_o = w_n1;
endmodule

module nand_serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // Counter must represent WIDTH itself, so size it for WIDTH+1 values.
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] C_LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic             cout_q;
  logic             in_ready_q;
  logic             out_valid_q;

  logic             w_l1;
  logic             w_r1;
  logic             w_l2;
  logic             sum_bit_d;
  logic             carry_d;
  logic [WIDTH-1:0] sum_d;

  // Full-adder cell: group 1 on the operand bits, group 2 adds the carry.
  nand_4_group u_grp1 (.x_i(a_q[0]), .y_i(b_q[0]),  .l_o(w_l1), .r_o(w_r1));
  nand_4_group u_grp2 (.x_i(w_r1),   .y_i(carry_q), .l_o(w_l2), .r_o(sum_bit_d));
  nand_gate    u_cgen (.a_i(w_l1),   .b_i(w_l2),    .y_o(carry_d));

  // Sum register shifts right with the new bit entering at the MSB.
  generate
    if (WIDTH == 1) begin : g_sum_w1
      assign sum_d = sum_bit_d;
    end else begin : g_sum_wn
      assign sum_d = {sum_bit_d, sum_q[WIDTH-1:1]};
    end
  endgenerate

  // Control FSM and datapath registers; reset overrides any handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      cout_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q        <= a;
            b_q        <= b;
            carry_q    <= cin;
            cnt_q      <= '0;
            sum_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= SHIFT;
          end
        end
        SHIFT: begin
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          sum_q   <= sum_d;
          carry_q <= carry_d;
          cnt_q   <= cnt_q + CW'(1);
          // The last bit's carry becomes the published carry-out.
          if (cnt_q == C_LAST_BIT) begin
            cout_q      <= carry_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule
`default_nettype wire

// File: tb/tb_nand_serial_adder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_nand_serial_adder                                      |
// | Purpose  : Scoreboard bench for nand_serial_adder (WIDTH=8): directed |
// |            cases plus random operands against a + b + cin.           |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_nand_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;

  int checks   = 0;
  int failures = 0;

  // Expected {cout,sum} per accepted operand set, oldest first.
  logic [W:0] exp_q[$];
  logic       mon_prev;
  logic [W:0] mon_e;

  nand_serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain unsigned addition widened by one bit.
  function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic c);
    return (W+1)'(x) + (W+1)'(y) + (W+1)'(c);
  endfunction

  // Monitor: each new result presentation is popped and compared.
  initial begin
    mon_prev = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (out_valid && !mon_prev) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL result: got 0x%0h expected none (queue empty)", {cout, sum});
        end else begin
          mon_e = exp_q.pop_front();
          chk("result", 32'({cout, sum}), 32'(mon_e));
        end
      end
      mon_prev = out_valid;
    end
  end

  // One full transaction: accept, latency, optional backpressure, handshake.
  task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv,
                      input int hold, input bit noisy);
    int         n;
    logic [W:0] e;
    e = ref_add(av, bv, cv);
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    a        = av;
    b        = bv;
    cin      = cv;
    in_valid = 1'b1;
    @(posedge clk);
    exp_q.push_back(e);
    #1;
    in_valid = 1'b0;
    chk("in_ready_busy", 32'(in_ready), 32'd0);
    n = 0;
    while (!out_valid && n < 40) begin
      if (noisy) begin
        in_valid  = 1'b1;
        a         = W'($urandom);
        b         = W'($urandom);
        cin       = 1'($urandom);
        out_ready = 1'($urandom);
      end
      @(posedge clk);
      #1;
      n++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("latency", 32'(n), 32'(W));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk("hold_result", 32'({cout, sum}), 32'(e));
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("post_hs_valid", 32'(out_valid), 32'd0);
    chk("post_hs_in_ready", 32'(in_ready), 32'd1);
    chk("retain_result", 32'({cout, sum}), 32'(e));
  endtask

  // Abort an operation after 3 SHIFT cycles; reset wins over handshakes.
  task automatic reset_mid_shift();
    logic [W:0] dropped;
    a        = 8'hAA;
    b        = 8'h55;
    cin      = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    exp_q.push_back(ref_add(8'hAA, 8'h55, 1'b1));
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset     = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dropped   = exp_q.pop_back();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    @(posedge clk);
    #1;
    chk("rst_idle_stays", 32'(in_ready), 32'd1);
    send(8'h01, 8'h01, 1'b0, 0, 1'b0);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_sum", 32'(sum), 32'd0);
    chk("reset_cout", 32'(cout), 32'd0);

    send(8'h5A, 8'h3C, 1'b0, 0, 1'b0);
    send(8'hFF, 8'h01, 1'b0, 0, 1'b0);
    send(8'hFF, 8'hFF, 1'b1, 0, 1'b0);
    send(8'h81, 8'h7F, 1'b1, 5, 1'b0);
    send(8'h12, 8'h34, 1'b1, 2, 1'b1);
    reset_mid_shift();
    send(8'h00, 8'h00, 1'b0, 1, 1'b0);

    for (int k = 0; k < 25; k++) begin
      send(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
           bit'($urandom_range(0, 1)));
    end

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
